// File: rtl/ecg_seq_pkg.sv
// Shared types and default widths for the ECG waveform playback path.
// The optional amplitude-scaling feature is enabled by defining ECG_AMP_SCALE_EN.
package ecg_seq_pkg;

    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 16;
    localparam int PHASE_W = 24;
    localparam int BEAT_W  = 8;

    localparam logic [7:0] GAIN_UNITY = 8'd128;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/ecg_phase_acc.sv
// Phase accumulator: PHASE_W-bit register advanced by i_step on each enable.
// o_carry flags the wrap produced by the add that the current enable commits.
module ecg_phase_acc #(
    parameter int PHASE_W = ecg_seq_pkg::PHASE_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clr,
    input  logic               i_en,
    input  logic [PHASE_W-1:0] i_step,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_carry
);
    import ecg_seq_pkg::*;

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W:0]   w_sum;

    assign w_sum   = {1'b0, r_phase} + {1'b0, i_step};
    assign o_carry = i_en & w_sum[PHASE_W];
    assign o_phase = r_phase;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_phase <= '0;
        end else if (i_en) begin
            r_phase <= w_sum[PHASE_W-1:0];
        end
    end

endmodule

// File: rtl/ecg_wave_sequencer.sv
// ECG LUT playback: phase-accumulator addressing, registered valid/ready sample stream,
// beat counting and start/stop control. Define ECG_AMP_SCALE_EN to add the i_gain scaler.
module ecg_wave_sequencer #(
    parameter int ADDR_W  = ecg_seq_pkg::ADDR_W,
    parameter int DATA_W  = ecg_seq_pkg::DATA_W,
    parameter int PHASE_W = ecg_seq_pkg::PHASE_W,
    parameter int BEAT_W  = ecg_seq_pkg::BEAT_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic [PHASE_W-1:0] i_fcw,
    input  logic [BEAT_W-1:0]  i_beats,
`ifdef ECG_AMP_SCALE_EN
    input  logic [7:0]         i_gain,
`endif
    output logic [ADDR_W-1:0]  o_lut_addr,
    input  logic [DATA_W-1:0]  i_lut_data,
    output logic [DATA_W-1:0]  o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_busy,
    output logic               o_done
);
    import ecg_seq_pkg::*;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PHASE_W-1:0] r_fcw_q;
    logic [BEAT_W-1:0]  r_beats_q;
    logic [BEAT_W-1:0]  r_beat_cnt;
    logic [BEAT_W-1:0]  w_beat_inc;
    logic [DATA_W-1:0]  r_data_p1;
    logic               r_vld_p1;
    logic               r_done;
    logic [PHASE_W-1:0] w_phase;
    logic               w_carry;
    logic               w_start;
    logic               w_load;
    logic               w_drain;
    logic [DATA_W-1:0]  w_sample_p0;
    logic               w_unused_frac;

    assign w_start    = (r_state == IDLE) && i_start;
    assign w_load     = (r_state == RUN) && !i_stop && (!r_vld_p1 || i_ready);
    assign w_drain    = (r_state == DONE) && (!r_vld_p1 || i_ready);
    assign w_beat_inc = r_beat_cnt + 1'b1;

    ecg_phase_acc #(
        .PHASE_W (PHASE_W)
    ) u_phase_acc (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_start),
        .i_en    (w_load),
        .i_step  (r_fcw_q),
        .o_phase (w_phase),
        .o_carry (w_carry)
    );

    assign o_lut_addr    = w_phase[PHASE_W-1 -: ADDR_W];
    assign w_unused_frac = ^w_phase[PHASE_W-ADDR_W-1:0];

`ifdef ECG_AMP_SCALE_EN
    logic [7:0] r_gain_q;

    // Q1.7 gain: product >> 7, clipped to full-scale instead of wrapping
    function automatic logic [DATA_W-1:0] sat_scale(input logic [DATA_W-1:0] d,
                                                    input logic [7:0]        g);
        logic [DATA_W+7:0] prod;
        prod = (DATA_W+8)'(d) * (DATA_W+8)'(g);
        prod = prod >> 7;
        return (|prod[DATA_W+7:DATA_W]) ? '1 : prod[DATA_W-1:0];
    endfunction

    assign w_sample_p0 = sat_scale(i_lut_data, r_gain_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_gain_q <= '0;
        end else if (w_start) begin
            r_gain_q <= i_gain;
        end
    end
`else
    assign w_sample_p0 = i_lut_data;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_start) w_state_nxt = RUN;
            end
            RUN: begin
                if (i_stop) begin
                    w_state_nxt = DONE;
                end else if (w_load && w_carry && (r_beats_q != '0) && (w_beat_inc == r_beats_q)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_drain) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---- p0 -> p1: LUT word (optionally scaled) captured into the output register ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fcw_q    <= '0;
            r_beats_q  <= '0;
            r_beat_cnt <= '0;
            r_data_p1  <= '0;
            r_vld_p1   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_drain;
            if (w_start) begin
                r_fcw_q    <= i_fcw;
                r_beats_q  <= i_beats;
                r_beat_cnt <= '0;
            end
            if (w_load) begin
                r_data_p1 <= w_sample_p0;
                r_vld_p1  <= 1'b1;
                if (w_carry && (r_beat_cnt != '1)) r_beat_cnt <= w_beat_inc;
            end else if (i_ready) begin
                // An accepted sample that is not replaced (stop or drain) must not be offered twice
                r_vld_p1 <= 1'b0;
            end
        end
    end

    assign o_data  = r_data_p1;
    assign o_valid = r_vld_p1;
    assign o_busy  = (r_state != IDLE);
    assign o_done  = r_done;

endmodule
